microcode_sequencer: RTL and testbench

//  Drives the 9-bit microcode address into microcode_mod and consumes its control word.

---
 rtl/microcode_sequencer.sv | 122 ++++++++++++
 tb/tb_microcode_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches opcode bytes (0xCB prefix folded into addr[8]) and walks ROM steps via next/last.
// Latency: accepted byte -> live uop_addr one edge later; each unstalled step advances one per clock.
// Backpressure: fetch_req held until fetch_ready; stall freezes the current step. MICROSEQ_IRQ_EN adds irq entry.
module microcode_sequencer #(
    parameter int                ADDR_W    = 9,
    parameter logic [7:0]        CB_PREFIX = 8'hCB,
    parameter logic [7:0]        HALT_OP   = 8'h76,
    parameter logic [ADDR_W-1:0] IRQ_ENTRY = 9'h120
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              fetch_req,
    input  logic              fetch_ready,
    input  logic [7:0]        fetch_data,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_valid,
    input  logic [ADDR_W-1:0] uop_next,
    input  logic              uop_last,
    input  logic              stall,
    output logic              instr_start,
    output logic              halted
`ifdef MICROSEQ_IRQ_EN
    ,
    input  logic              irq_pending,
    output logic              irq_ack
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t state;
    logic   cb;
    logic   is_halt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_FETCH;
            cb          <= 1'b0;
            is_halt     <= 1'b0;
            uop_addr    <= '0;
            uop_valid   <= 1'b0;
            fetch_req   <= 1'b0;
            instr_start <= 1'b0;
            halted      <= 1'b0;
`ifdef MICROSEQ_IRQ_EN
            irq_ack     <= 1'b0;
`endif
        end else begin
            instr_start <= 1'b0;
`ifdef MICROSEQ_IRQ_EN
            irq_ack     <= 1'b0;
`endif
            case (state)
                S_FETCH: begin
                    uop_valid <= 1'b0;
                    // Only the cycle right after reset reaches FETCH with fetch_req low.
                    if (!fetch_req) begin
                        fetch_req <= 1'b1;
                    end else if (fetch_ready) begin
                        if (fetch_data == CB_PREFIX && !cb) begin
                            cb <= 1'b1;
                        end else begin
                            uop_addr    <= ADDR_W'({cb, fetch_data});
                            is_halt     <= !cb && (fetch_data == HALT_OP);
                            cb          <= 1'b0;
                            fetch_req   <= 1'b0;
                            uop_valid   <= 1'b1;
                            instr_start <= 1'b1;
                            state       <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        if (!uop_last) begin
                            uop_addr <= uop_next;
                        end else begin
`ifdef MICROSEQ_IRQ_EN
                            if (irq_pending) begin
                                uop_addr    <= IRQ_ENTRY;
                                irq_ack     <= 1'b1;
                                instr_start <= 1'b1;
                                is_halt     <= 1'b0;
                            end else
`endif
                            if (is_halt) begin
                                state     <= S_HALT;
                                halted    <= 1'b1;
                                uop_valid <= 1'b0;
                            end else begin
                                state     <= S_FETCH;
                                uop_valid <= 1'b0;
                                fetch_req <= 1'b1;
                            end
                        end
                    end
                end
                S_HALT: begin
                    uop_valid <= 1'b0;
                    fetch_req <= 1'b0;
`ifdef MICROSEQ_IRQ_EN
                    if (irq_pending) begin
                        uop_addr    <= IRQ_ENTRY;
                        irq_ack     <= 1'b1;
                        instr_start <= 1'b1;
                        is_halt     <= 1'b0;
                        halted      <= 1'b0;
                        uop_valid   <= 1'b1;
                        state       <= S_EXEC;
                    end
`endif
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed cases plus randomized instructions checked against a transaction model.
module tb_microcode_sequencer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fetch_req;
    logic       fetch_ready = 1'b0;
    logic [7:0] fetch_data = 8'h00;
    logic [8:0] uop_addr;
    logic       uop_valid;
    logic [8:0] uop_next = 9'h000;
    logic       uop_last = 1'b0;
    logic       stall = 1'b0;
    logic       instr_start;
    logic       halted;
`ifdef MICROSEQ_IRQ_EN
    logic       irq_pending = 1'b0;
    logic       irq_ack;
`endif

    int errors = 0;
    int checks = 0;

    microcode_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .uop_addr(uop_addr), .uop_valid(uop_valid), .uop_next(uop_next), .uop_last(uop_last),
        .stall(stall), .instr_start(instr_start), .halted(halted)
`ifdef MICROSEQ_IRQ_EN
        , .irq_pending(irq_pending), .irq_ack(irq_ack)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for fetch_req, optionally idles, then presents one byte for one cycle.
    task automatic send_byte(input logic [7:0] b, input int delay);
        int n;
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_wait", {15'd0, fetch_req}, 16'd1);
        repeat (delay) @(negedge clk);
        chk("fetch_req_held", {15'd0, fetch_req}, 16'd1);
        fetch_data  = b;
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        fetch_data  = 8'($urandom);
    endtask

    // One instruction: optional prefix, opcode, nsteps ROM steps with random next addresses and stalls.
    task automatic run_instr(input bit pref, input logic [7:0] op, input int nsteps, input bit to_halt);
        logic [8:0] cur;
        logic [8:0] nx;
        int         st;
        if (pref) begin
            send_byte(8'hCB, int'($urandom_range(0, 2)));
            chk("cb_no_exec", {15'd0, uop_valid}, 16'd0);
            chk("cb_fetch_req", {15'd0, fetch_req}, 16'd1);
        end
        send_byte(op, int'($urandom_range(0, 2)));
        cur = {pref, op};
        chk("first_addr", {7'd0, uop_addr}, {7'd0, cur});
        chk("first_valid", {15'd0, uop_valid}, 16'd1);
        chk("instr_start", {15'd0, instr_start}, 16'd1);
        for (int i = 0; i < nsteps; i++) begin
            st = int'($urandom_range(0, 2));
            nx = 9'($urandom);
            for (int s = 0; s < st; s++) begin
                stall    = 1'b1;
                uop_last = 1'($urandom);
                uop_next = 9'($urandom);
                @(negedge clk);
                chk("stall_hold", {7'd0, uop_addr}, {7'd0, cur});
                chk("stall_valid", {15'd0, uop_valid}, 16'd1);
                chk("start_once", {15'd0, instr_start}, 16'd0);
            end
            stall    = 1'b0;
            uop_last = (i == nsteps - 1);
            uop_next = nx;
            @(negedge clk);
            uop_last = 1'b0;
            if (i < nsteps - 1) begin
                cur = nx;
                chk("advance", {7'd0, uop_addr}, {7'd0, cur});
                chk("advance_start", {15'd0, instr_start}, 16'd0);
            end else begin
                chk("bound_valid", {15'd0, uop_valid}, 16'd0);
                chk("bound_addr_hold", {7'd0, uop_addr}, {7'd0, cur});
                chk("bound_fetch_req", {15'd0, fetch_req}, {15'd0, !to_halt});
                chk("bound_halted", {15'd0, halted}, {15'd0, to_halt});
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_fetch_req", {15'd0, fetch_req}, 16'd0);
        chk("rst_valid", {15'd0, uop_valid}, 16'd0);
        chk("rst_addr", {7'd0, uop_addr}, 16'd0);
        chk("rst_start", {15'd0, instr_start}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
`ifdef MICROSEQ_IRQ_EN
        chk("rst_irq_ack", {15'd0, irq_ack}, 16'd0);
`endif
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit         p;
        logic [7:0] op;
        // Reset and first release.
        #1;
        check_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        chk("req_low_at_release", {15'd0, fetch_req}, 16'd0);
        @(negedge clk);
        chk("req_rises", {15'd0, fetch_req}, 16'd1);

        // Single-step 0x00, prefixed 0x37, and CB CB.
        run_instr(1'b0, 8'h00, 1, 1'b0);
        run_instr(1'b1, 8'h37, 1, 1'b0);
        run_instr(1'b1, 8'hCB, 1, 1'b0);

        // Directed 3-step chain with a two-cycle stall on step 2.
        send_byte(8'h42, 0);
        chk("chain0", {7'd0, uop_addr}, 16'h042);
        uop_next = 9'h101;
        @(negedge clk);
        chk("chain1", {7'd0, uop_addr}, 16'h101);
        stall = 1'b1; uop_last = 1'b1; uop_next = 9'h1FF;
        @(negedge clk);
        chk("chain_stall_a", {7'd0, uop_addr}, 16'h101);
        @(negedge clk);
        chk("chain_stall_b", {7'd0, uop_addr}, 16'h101);
        stall = 1'b0; uop_last = 1'b0; uop_next = 9'h102;
        @(negedge clk);
        chk("chain2", {7'd0, uop_addr}, 16'h102);
        uop_last = 1'b1;
        @(negedge clk);
        uop_last = 1'b0;
        chk("chain_end_req", {15'd0, fetch_req}, 16'd1);

        // Randomized instruction stream.
        for (int k = 0; k < 40; k++) begin
            p  = 1'($urandom);
            op = 8'($urandom);
            if (!p && op == 8'hCB) op = 8'hCC;
            if (!p && op == 8'h76) op = 8'h77;
            run_instr(p, op, int'($urandom_range(1, 4)), 1'b0);
        end

        // Reset in EXEC after a prefixed fetch, then reset between prefix and opcode.
        send_byte(8'hCB, 0);
        send_byte(8'h37, 0);
        chk("pre_reset_addr", {7'd0, uop_addr}, 16'h137);
        pulse_reset();
        run_instr(1'b0, 8'h37, 1, 1'b0);
        send_byte(8'hCB, 0);
        pulse_reset();
        run_instr(1'b0, 8'h37, 2, 1'b0);

`ifdef MICROSEQ_IRQ_EN
        send_byte(8'h10, 0);
        irq_pending = 1'b1; uop_next = 9'h055;
        @(negedge clk);
        chk("irq_mid_addr", {7'd0, uop_addr}, 16'h055);
        chk("irq_mid_ack", {15'd0, irq_ack}, 16'd0);
        uop_last = 1'b1;
        @(negedge clk);
        chk("irq_addr", {7'd0, uop_addr}, 16'h120);
        chk("irq_ack", {15'd0, irq_ack}, 16'd1);
        chk("irq_start", {15'd0, instr_start}, 16'd1);
        chk("irq_valid", {15'd0, uop_valid}, 16'd1);
        irq_pending = 1'b0;
        @(negedge clk);
        uop_last = 1'b0;
        chk("irq_ack_pulse", {15'd0, irq_ack}, 16'd0);
        chk("irq_ret_req", {15'd0, fetch_req}, 16'd1);
`endif

        // HALT opcode: sticks until reset (or interrupt when enabled).
        run_instr(1'b0, 8'h76, 2, 1'b1);
        for (int c = 0; c < 5; c++) begin
            fetch_ready = 1'($urandom);
            @(negedge clk);
            chk("halt_stays", {15'd0, halted}, 16'd1);
            chk("halt_no_req", {15'd0, fetch_req}, 16'd0);
            chk("halt_no_valid", {15'd0, uop_valid}, 16'd0);
        end
        fetch_ready = 1'b0;
`ifdef MICROSEQ_IRQ_EN
        irq_pending = 1'b1;
        @(negedge clk);
        irq_pending = 1'b0;
        chk("halt_irq_halted", {15'd0, halted}, 16'd0);
        chk("halt_irq_ack", {15'd0, irq_ack}, 16'd1);
        chk("halt_irq_addr", {7'd0, uop_addr}, 16'h120);
        chk("halt_irq_valid", {15'd0, uop_valid}, 16'd1);
`endif
        pulse_reset();
        run_instr(1'b0, 8'h01, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
